// File: rtl/pcm_arb_pkg.sv
// pcm_arb_pkg: shared FSM encoding and default sizing for the PCM ROM arbiter.
package pcm_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam int AW_DEF = 21;
  localparam int DW_DEF = 8;
  localparam int TO_CYC_DEF = 255;
endpackage

// File: rtl/pcm_arb_line.sv
// pcm_arb_line: one-entry tag/data cache line with fill, flush and hit compare.
module pcm_arb_line
  import pcm_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          fill,
  input  logic [AW-1:0] fill_tag,
  input  logic [DW-1:0] fill_data,
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [DW-1:0] data
);
  logic          valid;
  logic [AW-1:0] tag;
  // flush beats a coincident fill: the entry ends invalid
  always_ff @(posedge clk)
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      valid <= flush ? 1'b0 : (fill | valid);
      if (fill) begin
        tag  <= fill_tag;
        data <= fill_data;
      end
    end
  assign hit = valid && tag == addr;
endmodule

// File: rtl/pcm_rom_arbiter.sv
// pcm_rom_arbiter: shares one SDRAM PCM read port between two ADPCM fetchers with per-port one-byte caches.
module pcm_rom_arbiter
  import pcm_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic          CLK96,
  input  logic          RESET96_N,
  input  logic          FLUSH,
  input  logic          REQ0_CS,
  input  logic [AW-1:0] REQ0_ADDR,
  output logic [DW-1:0] REQ0_DATA,
  output logic          REQ0_OK,
  input  logic          REQ1_CS,
  input  logic [AW-1:0] REQ1_ADDR,
  output logic [DW-1:0] REQ1_DATA,
  output logic          REQ1_OK,
  output logic          ROM_CS,
  output logic [AW-1:0] ROM_ADDR,
  input  logic          ROM_OK,
  input  logic [DW-1:0] ROM_DATA,
  output logic          TIMEOUT
);
  state_t     state, nxt;
  logic       hit0, hit1, pend0, pend1, g, rr, gsel, done, expire, fill0, fill1;
  logic [7:0] cnt;

  pcm_arb_line #(.AW(AW), .DW(DW)) line0 (
    .clk(CLK96), .rst_n(RESET96_N), .flush(FLUSH), .fill(fill0), .fill_tag(ROM_ADDR),
    .fill_data(ROM_DATA), .addr(REQ0_ADDR), .hit(hit0), .data(REQ0_DATA)
  );
  pcm_arb_line #(.AW(AW), .DW(DW)) line1 (
    .clk(CLK96), .rst_n(RESET96_N), .flush(FLUSH), .fill(fill1), .fill_tag(ROM_ADDR),
    .fill_data(ROM_DATA), .addr(REQ1_ADDR), .hit(hit1), .data(REQ1_DATA)
  );

  assign REQ0_OK = REQ0_CS && hit0;
  assign REQ1_OK = REQ1_CS && hit1;
  assign pend0   = REQ0_CS && !hit0;
  assign pend1   = REQ1_CS && !hit1;

  always_ff @(posedge CLK96)
    if (!RESET96_N) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    nxt = state == IDLE  ? ((pend0 | pend1) ? ISSUE : IDLE) :
          state == ISSUE ? WAIT :
          (done | expire) ? IDLE : WAIT;
  end

  // ROM_OK during ISSUE may belong to the previous address, so only WAIT looks at it
  always_comb begin
    g      = (pend0 && pend1) ? rr : pend1;
    done   = state == WAIT && ROM_OK;
    expire = state == WAIT && !ROM_OK && cnt == 8'(TO_CYC);
    fill0  = done && !gsel;
    fill1  = done && gsel;
  end

  always_ff @(posedge CLK96)
    if (!RESET96_N) begin
      ROM_CS   <= 1'b0;
      ROM_ADDR <= '0;
      rr       <= 1'b0;
      gsel     <= 1'b0;
      cnt      <= '0;
      TIMEOUT  <= 1'b0;
    end else begin
      TIMEOUT <= expire;
      if (state == IDLE && (pend0 | pend1)) begin
        ROM_CS   <= 1'b1;
        ROM_ADDR <= g ? REQ1_ADDR : REQ0_ADDR;
        gsel     <= g;
      end
      if (state == ISSUE) cnt <= '0;
      else if (state == WAIT && !ROM_OK && !expire) cnt <= cnt + 8'd1;
      if (done | expire) begin
        ROM_CS <= 1'b0;
        rr     <= ~gsel;
      end
    end
endmodule
